// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: opcode encodings and
// the helper that spreads log levels across pipeline stages.
package shift_pkg;

    localparam logic [2:0] OP_SLL  = 3'd0;
    localparam logic [2:0] OP_SRL  = 3'd1;
    localparam logic [2:0] OP_SRA  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd5;

    // Levels per stage; the final stage takes whatever is left over.
    function automatic int group_size(input int levels, input int stages);
        return (levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One log level of the right-shift network: shifts or rotates right by SHIFT
// when enabled, back-filling with fill_i for plain shifts.
module barrel_shift_level #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT      = 1
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  en_i,
    input  logic                  rotate_i,
    input  logic                  fill_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [SHIFT-1:0] top_bits;

    assign top_bits = rotate_i ? data_i[SHIFT-1:0] : {SHIFT{fill_i}};
    assign data_o   = en_i ? {top_bits, data_i[DATA_WIDTH-1:SHIFT]} : data_i;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides. Left operations run
// through the right-shift network on a bit-reversed operand.
module barrel_shift_pipe
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STAGES     = 2,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_shamt,
    input  logic [2:0]            in_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_carry,
    output logic                  out_zero,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int W = DATA_WIDTH;
    localparam int A = ADDR_WIDTH;
    localparam int G = group_size(A, STAGES);
    localparam logic [A-1:0] SH_ONE = 1;

    logic [STAGES-1:0]    valid_q;
    logic [STAGES-1:0]    adv;
    logic [W-1:0]         dat_q   [STAGES];
    logic [A-1:0]         sh_q    [STAGES];
    logic                 rot_q   [STAGES];
    logic                 fill_q  [STAGES];
    logic                 left_q  [STAGES];
    logic                 carry_q [STAGES];
    logic [TAG_WIDTH-1:0] tag_q   [STAGES];
    logic                 zero_q;

    logic         in_left, in_rot, in_fill, in_pass, in_carry;
    logic [A-1:0] idx_l, idx_r, in_sh;
    logic [W-1:0] in_rev, in_pre;

    for (genvar b = 0; b < W; b++) begin : g_rev_in
        assign in_rev[b] = in_data[W-1-b];
    end

    // Carry is taken from the operand so it never depends on the network.
    always_comb begin
        in_left = 1'b0;
        in_rot  = 1'b0;
        in_fill = 1'b0;
        in_pass = (in_op >= OP_PASS);
        case (in_op)
            OP_SLL:  in_left = 1'b1;
            OP_SRL:  ;
            OP_SRA:  in_fill = in_data[W-1];
            OP_ROR:  in_rot = 1'b1;
            OP_ROL:  begin
                in_left = 1'b1;
                in_rot  = 1'b1;
            end
            default: ;
        endcase
        idx_r    = in_shamt - SH_ONE;
        idx_l    = ~in_shamt + SH_ONE;
        in_carry = 1'b0;
        if (!in_pass && (in_shamt != '0)) begin
            in_carry = in_left ? in_data[idx_l] : in_data[idx_r];
        end
        in_sh  = in_pass ? '0 : in_shamt;
        in_pre = in_left ? in_rev : in_data;
    end

    always_comb begin
        logic all_full;
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            all_full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                all_full = all_full & valid_q[j];
            end
            adv[k] = out_ready | ~all_full;
        end
    end

    assign in_ready = adv[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (adv[0]) valid_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) valid_q[k] <= valid_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * G;
        localparam int HI = (LO + G > A) ? A : LO + G;
        localparam int N  = (HI > LO) ? HI - LO : 0;

        logic [W-1:0]         src_dat;
        logic [A-1:0]         src_sh;
        logic                 src_rot, src_fill, src_left, src_carry;
        logic [TAG_WIDTH-1:0] src_tag;
        logic [W-1:0]         chain [N+1];
        logic [W-1:0]         dat_d;
        logic                 unused_src;

        if (k == 0) begin : g_src_in
            assign src_dat   = in_pre;
            assign src_sh    = in_sh;
            assign src_rot   = in_rot;
            assign src_fill  = in_fill;
            assign src_left  = in_left;
            assign src_carry = in_carry;
            assign src_tag   = in_tag;
        end else begin : g_src_pipe
            assign src_dat   = dat_q[k-1];
            assign src_sh    = sh_q[k-1];
            assign src_rot   = rot_q[k-1];
            assign src_fill  = fill_q[k-1];
            assign src_left  = left_q[k-1];
            assign src_carry = carry_q[k-1];
            assign src_tag   = tag_q[k-1];
        end

        assign chain[0]   = src_dat;
        assign unused_src = ^{src_sh, src_rot, src_fill};

        for (genvar j = 0; j < N; j++) begin : g_lvl
            barrel_shift_level #(
                .DATA_WIDTH(W),
                .SHIFT     (1 << (LO + j))
            ) u_lvl (
                .data_i  (chain[j]),
                .en_i    (src_sh[LO + j]),
                .rotate_i(src_rot),
                .fill_i  (src_fill),
                .data_o  (chain[j+1])
            );
        end

        if (k == STAGES - 1) begin : g_last
            logic [W-1:0] grp_rev;
            logic         unused_tail;
            for (genvar b = 0; b < W; b++) begin : g_rev_out
                assign grp_rev[b] = chain[N][W-1-b];
            end
            assign dat_d       = src_left ? grp_rev : chain[N];
            assign unused_tail = ^{sh_q[k], rot_q[k], fill_q[k], left_q[k]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) zero_q <= 1'b0;
                else if (adv[k]) zero_q <= (dat_d == '0);
            end
        end else begin : g_mid
            assign dat_d = chain[N];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dat_q[k]   <= '0;
                sh_q[k]    <= '0;
                rot_q[k]   <= 1'b0;
                fill_q[k]  <= 1'b0;
                left_q[k]  <= 1'b0;
                carry_q[k] <= 1'b0;
                tag_q[k]   <= '0;
            end else if (adv[k]) begin
                dat_q[k]   <= dat_d;
                sh_q[k]    <= src_sh;
                rot_q[k]   <= src_rot;
                fill_q[k]  <= src_fill;
                left_q[k]  <= src_left;
                carry_q[k] <= src_carry;
                tag_q[k]   <= src_tag;
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];
    assign out_carry = carry_q[STAGES-1];
    assign out_zero  = zero_q;
    assign out_tag   = tag_q[STAGES-1];

endmodule
